// File: rtl/ecc_pkg.sv
// ecc_pkg: shared definitions for the ECC scrub engine.
//   CODE_W        width of a SECDED codeword (8 data + 4 Hamming + 1 overall parity)
//   DATA_W        width of the data payload
//   scrub_state_t scrubber FSM states; IDLE encodes as 0 so a reset state reads as all-zero
package ecc_pkg;

    localparam int CODE_W = 13;
    localparam int DATA_W = 8;

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        RD    = 3'd1,
        RWAIT = 3'd2,
        CHK   = 3'd3,
        WR    = 3'd4,
        NEXT  = 3'd5,
        DONE  = 3'd6
    } scrub_state_t;

endpackage

// File: rtl/ecc_scrub_timer.sv
// ecc_scrub_timer: idle-interval counter for automatic scrub passes.
// Only built when ECC_SCRUB_AUTO_EN is defined.
// Ports:
//   clk    in   1  clock
//   rst_n  in   1  async active-low reset
//   idle   in   1  scrubber is in IDLE; counter clears whenever this is low
//   fire   out  1  high on the INTERVAL-th consecutive idle cycle
`ifdef ECC_SCRUB_AUTO_EN
module ecc_scrub_timer #(
    parameter int INTERVAL = 1024
) (
    input  logic clk,
    input  logic rst_n,
    input  logic idle,
    output logic fire
);

    localparam int W = $clog2(INTERVAL + 1);

    logic [W-1:0] cnt;

    assign fire = idle && (cnt == W'(INTERVAL - 1));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!idle || fire) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + W'(1);
        end
    end

endmodule
`endif

// File: rtl/hamming_decoder.sv
// hamming_decoder: SECDED decoder for the hamming_encoder codeword layout.
// Ports:
//   code_in         in   13  received codeword
//   data_out        out  8   data, with a single-bit error corrected
//   error           out  1   any error detected
//   undefined_data  out  1   uncorrectable error; data_out is not trustworthy
module hamming_decoder
    import ecc_pkg::*;
(
    input  logic [CODE_W-1:0] code_in,
    output logic [DATA_W-1:0] data_out,
    output logic              error,
    output logic              undefined_data
);

    logic [3:0]  syn;
    logic        par;
    logic [11:0] flip;
    logic [11:0] fixed;

    assign syn[0] = code_in[0] ^ code_in[2] ^ code_in[4] ^ code_in[6] ^ code_in[8] ^ code_in[10];
    assign syn[1] = code_in[1] ^ code_in[2] ^ code_in[5] ^ code_in[6] ^ code_in[9] ^ code_in[10];
    assign syn[2] = code_in[3] ^ code_in[4] ^ code_in[5] ^ code_in[6] ^ code_in[11];
    assign syn[3] = code_in[7] ^ code_in[8] ^ code_in[9] ^ code_in[10] ^ code_in[11];
    assign par    = ^code_in;

    // Odd overall parity means a single flip; the syndrome then names the
    // Hamming position (0 = the overall parity bit itself, no data repair).
    always_comb begin
        flip = '0;
        if (par && (syn != 4'd0) && (syn <= 4'd12)) begin
            flip[syn - 4'd1] = 1'b1;
        end
    end

    assign fixed          = code_in[11:0] ^ flip;
    assign data_out       = {fixed[11], fixed[10], fixed[9], fixed[8],
                             fixed[6], fixed[5], fixed[4], fixed[2]};
    assign error          = (syn != 4'd0) || par;
    // Even parity with a nonzero syndrome is a double flip; odd parity with a
    // syndrome beyond position 12 cannot come from any single flip.
    assign undefined_data = ((syn != 4'd0) && !par) || (par && (syn > 4'd12));

endmodule

// File: rtl/hamming_encoder.sv
// hamming_encoder: SECDED encoder, 8 data bits -> 13-bit codeword.
// Codeword layout (index = Hamming position - 1 for bits 0..11):
//   [0]=p1 [1]=p2 [2]=d0 [3]=p4 [4]=d1 [5]=d2 [6]=d3 [7]=p8
//   [8]=d4 [9]=d5 [10]=d6 [11]=d7 [12]=overall parity of [11:0]
// Ports:
//   data_in   in   8   data to protect
//   code_out  out  13  encoded codeword
module hamming_encoder
    import ecc_pkg::*;
(
    input  logic [DATA_W-1:0] data_in,
    output logic [CODE_W-1:0] code_out
);

    logic [11:0] ham;

    always_comb begin
        ham     = '0;
        ham[2]  = data_in[0];
        ham[4]  = data_in[1];
        ham[5]  = data_in[2];
        ham[6]  = data_in[3];
        ham[8]  = data_in[4];
        ham[9]  = data_in[5];
        ham[10] = data_in[6];
        ham[11] = data_in[7];
        ham[0]  = data_in[0] ^ data_in[1] ^ data_in[3] ^ data_in[4] ^ data_in[6];
        ham[1]  = data_in[0] ^ data_in[2] ^ data_in[3] ^ data_in[5] ^ data_in[6];
        ham[3]  = data_in[1] ^ data_in[2] ^ data_in[3] ^ data_in[7];
        ham[7]  = data_in[4] ^ data_in[5] ^ data_in[6] ^ data_in[7];
    end

    assign code_out = {^ham, ham};

endmodule

// File: rtl/ecc_scrubber.sv
// ecc_scrubber: background scrub engine for a 2**ADDR_W x 13-bit SECDED memory.
// Walks the address range, corrects single-bit errors by writing back a clean
// codeword, and counts/flags double-bit errors without writing.
// Optional feature macro: ECC_SCRUB_AUTO_EN (self-start after SCRUB_INTERVAL idle cycles).
// Ports:
//   clk, rst_n      clock, async active-low reset
//   start           begin one pass (ignored while busy, or when stop is high)
//   stop            abort the pass once the current memory transaction ends
//   clr_cnt         clear corr_cnt / uncorr_cnt / last_err_addr
//   mem_req/mem_we/mem_addr/mem_wdata, mem_ready, mem_rdata   memory port
//   busy            pass in progress (any state but IDLE)
//   done            1-cycle pulse when a full pass completes
//   corr_cnt        saturating count of corrected words
//   uncorr_cnt      saturating count of uncorrectable words
//   last_err_addr   address of the most recent uncorrectable word
//   err_irq         1-cycle pulse per uncorrectable word
//   state_dbg       current FSM state
//
// Memory handshake: a request (mem_req with mem_we/mem_addr/mem_wdata) is held
// stable until the cycle mem_ready is high; that cycle is the transfer. Read
// data arrives on mem_rdata in the cycle after the read transfer.
module ecc_scrubber
    import ecc_pkg::*;
#(
    parameter int ADDR_W         = 6,
    parameter int CNT_W          = 16,
    parameter int SCRUB_INTERVAL = 1024
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    input  logic              stop,
    input  logic              clr_cnt,
    output logic              mem_req,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [CODE_W-1:0] mem_wdata,
    input  logic              mem_ready,
    input  logic [CODE_W-1:0] mem_rdata,
    output logic              busy,
    output logic              done,
    output logic [CNT_W-1:0]  corr_cnt,
    output logic [CNT_W-1:0]  uncorr_cnt,
    output logic [ADDR_W-1:0] last_err_addr,
    output logic              err_irq,
    output logic [2:0]        state_dbg
);

    scrub_state_t      state, state_next;
    logic [ADDR_W-1:0] ptr;
    logic [CODE_W-1:0] code_q;
    logic              stop_pend;
    logic [DATA_W-1:0] dec_data;
    logic              dec_error;
    logic              dec_undef;
    logic [CODE_W-1:0] enc_code;
    logic              go;
    logic              abort;
    logic              ptr_last;
    logic              corr_evt;
    logic              uncorr_evt;

    hamming_decoder u_dec (
        .code_in        (code_q),
        .data_out       (dec_data),
        .error          (dec_error),
        .undefined_data (dec_undef)
    );

    hamming_encoder u_enc (
        .data_in  (dec_data),
        .code_out (enc_code)
    );

`ifdef ECC_SCRUB_AUTO_EN
    logic auto_fire;

    ecc_scrub_timer #(
        .INTERVAL (SCRUB_INTERVAL)
    ) u_timer (
        .clk   (clk),
        .rst_n (rst_n),
        .idle  (state == IDLE),
        .fire  (auto_fire)
    );

    assign go = (start || auto_fire) && !stop;
`else
    assign go = start && !stop;
`endif

    // A stop seen mid-transaction is remembered until the FSM can honour it.
    assign abort      = stop || stop_pend;
    assign ptr_last   = (ptr == {ADDR_W{1'b1}});
    assign corr_evt   = (state == CHK) && dec_error && !dec_undef;
    assign uncorr_evt = (state == CHK) && dec_error && dec_undef;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            IDLE:    if (go) state_next = RD;
            RD:      if (mem_ready) state_next = abort ? IDLE : RWAIT;
            RWAIT:   state_next = abort ? IDLE : CHK;
            CHK: begin
                if (abort)         state_next = IDLE;
                else if (corr_evt) state_next = WR;
                else               state_next = NEXT;
            end
            WR:      if (mem_ready) state_next = abort ? IDLE : NEXT;
            NEXT: begin
                if (abort)         state_next = IDLE;
                else if (ptr_last) state_next = DONE;
                else               state_next = RD;
            end
            DONE:    state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    assign mem_req   = (state == RD) || (state == WR);
    assign mem_we    = (state == WR);
    assign mem_addr  = ptr;
    assign mem_wdata = (state == WR) ? enc_code : '0;
    assign busy      = (state != IDLE);
    assign done      = (state == DONE);
    assign err_irq   = uncorr_evt;
    assign state_dbg = state;

    // Pointer returns to 0 on pass completion and on every abort.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ptr <= '0;
        end else if ((state_next == IDLE) || ((state == NEXT) && ptr_last)) begin
            ptr <= '0;
        end else if (state == NEXT) begin
            ptr <= ptr + ADDR_W'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            stop_pend <= 1'b0;
        end else if (state_next == IDLE) begin
            stop_pend <= 1'b0;
        end else if (stop) begin
            stop_pend <= 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            code_q <= '0;
        end else if (state == RWAIT) begin
            code_q <= mem_rdata;
        end
    end

    // clr_cnt takes priority over a same-cycle event; counters stick at max.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            corr_cnt      <= '0;
            uncorr_cnt    <= '0;
            last_err_addr <= '0;
        end else if (clr_cnt) begin
            corr_cnt      <= '0;
            uncorr_cnt    <= '0;
            last_err_addr <= '0;
        end else begin
            if (corr_evt && (corr_cnt != {CNT_W{1'b1}})) begin
                corr_cnt <= corr_cnt + CNT_W'(1);
            end
            if (uncorr_evt) begin
                last_err_addr <= ptr;
                if (uncorr_cnt != {CNT_W{1'b1}}) begin
                    uncorr_cnt <= uncorr_cnt + CNT_W'(1);
                end
            end
        end
    end

endmodule
